uart_tx_core: RTL and testbench

//   UART serial transmitter. Completes the UART link on the transmit side,

---
 rtl/uart_tx_core.sv | 121 ++++++++++++
 tb/tb_uart_tx_core.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// UART transmitter: one word per DATA_VALID handshake, framed as start, data
// (LSB first), optional parity and stop, one bit per baud clock on TX_OUT.
module uart_tx_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] shift_p0;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  par_en_p0;
  logic                  par_bit_p0;
  logic                  tx_nxt;
  logic                  busy_nxt;
  logic                  load;
  logic                  shift_en;

  // PAR_TYP=0 selects the inverted XOR reduction, PAR_TYP=1 the plain one.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d,
                                      input logic typ);
    return typ ? (^d) : (~^d);
  endfunction

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (DATA_VALID) state_nxt = START;
      START:   state_nxt = DATA;
      DATA:    if (bit_cnt == LAST_BIT) state_nxt = par_en_p0 ? PARITY : STOP;
      PARITY:  state_nxt = STOP;
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_nxt   = 1'b1;
    busy_nxt = 1'b0;
    load     = 1'b0;
    shift_en = 1'b0;
    case (state)
      IDLE:    load = DATA_VALID;
      START: begin
        tx_nxt   = 1'b0;
        busy_nxt = 1'b1;
      end
      DATA: begin
        tx_nxt   = shift_p0[0];
        busy_nxt = 1'b1;
        shift_en = 1'b1;
      end
      PARITY: begin
        tx_nxt   = par_bit_p0;
        busy_nxt = 1'b1;
      end
      STOP:    busy_nxt = 1'b1;
      default: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
      end
    endcase
  end

  // Word capture and serialisation: parity is fixed at capture time.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      shift_p0   <= '0;
      bit_cnt    <= '0;
      par_en_p0  <= 1'b0;
      par_bit_p0 <= 1'b0;
    end else if (load) begin
      shift_p0   <= P_DATA;
      bit_cnt    <= '0;
      par_en_p0  <= PAR_EN;
      par_bit_p0 <= parity_bit(P_DATA, PAR_TYP);
    end else if (shift_en) begin
      shift_p0 <= shift_p0 >> 1;
      bit_cnt  <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
    end
  end

  // Line register: TX_OUT and Busy lag the state by one edge.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      TX_OUT <= 1'b1;
      Busy   <= 1'b0;
    end else begin
      TX_OUT <= tx_nxt;
      Busy   <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed testbench for uart_tx_core: frame contents, parity, Busy timing,
// dropped words while busy, back-to-back frames and mid-frame reset.
module tb_uart_tx_core;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       Busy;

  int n_pass;
  int n_total;

  uart_tx_core #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Presents a word and holds DATA_VALID until Busy is seen; returns at the
  // negedge where the start bit is on the line.
  task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt,
                             output bit ok);
    ok = 1'b0;
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (Busy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    DATA_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0; DATA_VALID = 1'b1; P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_total++;
      if (TX_OUT === 1'b1 && Busy === 1'b0) n_pass++;
      else $display("FAIL reset_cycle%0d: TX_OUT=%b Busy=%b, expected TX_OUT=1 Busy=0", i, TX_OUT, Busy);
    end
    DATA_VALID = 1'b0;
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_total++;
      if (TX_OUT === 1'b1 && Busy === 1'b0) n_pass++;
      else $display("FAIL reset_idle%0d: TX_OUT=%b Busy=%b, expected TX_OUT=1 Busy=0", i, TX_OUT, Busy);
    end
  endtask

  task automatic test_no_parity();
    int exp_bits[10] = '{0,1,0,1,0,0,1,0,1,1};
    int busy_cycles;
    bit ok;
    start_frame(8'hA5, 1'b0, 1'b0, ok);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL nopar_handshake: Busy never rose, expected within 20 cycles");
    busy_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge CLK);
      if (Busy === 1'b1) busy_cycles++;
      n_total++;
      if (TX_OUT === 1'(exp_bits[i])) n_pass++;
      else $display("FAIL nopar_bit%0d: TX_OUT=%b, expected %0d", i, TX_OUT, exp_bits[i]);
    end
    @(negedge CLK);
    n_total++;
    if (busy_cycles == 10 && Busy === 1'b0) n_pass++;
    else $display("FAIL nopar_busy_len: busy_cycles=%0d Busy_after=%b, expected 10 and 0", busy_cycles, Busy);
    n_total++;
    if (TX_OUT === 1'b1) n_pass++;
    else $display("FAIL nopar_idle_line: TX_OUT=%b, expected 1", TX_OUT);
  endtask

  task automatic test_parity();
    int exp_a[11] = '{0,1,0,1,0,0,1,0,1,1,1};
    int exp_b[11] = '{0,1,0,1,0,0,1,0,1,0,1};
    int exp_c[11] = '{0,1,1,1,0,0,0,0,0,1,1};
    int busy_cycles;
    bit ok;
    for (int f = 0; f < 3; f++) begin
      case (f)
        0: start_frame(8'hA5, 1'b1, 1'b0, ok);
        1: start_frame(8'hA5, 1'b1, 1'b1, ok);
        default: start_frame(8'h07, 1'b1, 1'b1, ok);
      endcase
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL par%0d_handshake: Busy never rose, expected within 20 cycles", f);
      // Changing the source word mid-frame must not disturb the frame.
      P_DATA = 8'h5A; PAR_TYP = ~PAR_TYP;
      busy_cycles = 0;
      for (int i = 0; i < 11; i++) begin
        int e;
        if (i > 0) @(negedge CLK);
        if (Busy === 1'b1) busy_cycles++;
        e = (f == 0) ? exp_a[i] : (f == 1) ? exp_b[i] : exp_c[i];
        n_total++;
        if (TX_OUT === 1'(e)) n_pass++;
        else $display("FAIL par%0d_bit%0d: TX_OUT=%b, expected %0d", f, i, TX_OUT, e);
      end
      @(negedge CLK);
      n_total++;
      if (busy_cycles == 11 && Busy === 1'b0 && TX_OUT === 1'b1) n_pass++;
      else $display("FAIL par%0d_end: busy_cycles=%0d Busy=%b TX_OUT=%b, expected 11,0,1", f, busy_cycles, Busy, TX_OUT);
    end
  endtask

  task automatic test_busy_ignore();
    bit ok;
    start_frame(8'h00, 1'b0, 1'b0, ok);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL ignore_handshake: Busy never rose, expected within 20 cycles");
    for (int i = 0; i < 10; i++) begin
      int e;
      if (i > 0) @(negedge CLK);
      if (i == 4) begin
        P_DATA = 8'hFF; DATA_VALID = 1'b1;
      end else if (i == 5) begin
        DATA_VALID = 1'b0;
      end
      e = (i == 9) ? 1 : 0;
      n_total++;
      if (TX_OUT === 1'(e)) n_pass++;
      else $display("FAIL ignore_bit%0d: TX_OUT=%b, expected %0d", i, TX_OUT, e);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      n_total++;
      if (TX_OUT === 1'b1 && Busy === 1'b0) n_pass++;
      else $display("FAIL ignore_after%0d: TX_OUT=%b Busy=%b, expected 1 and 0", i, TX_OUT, Busy);
    end
  endtask

  task automatic test_back_to_back();
    int exp_bits[10] = '{0,0,0,1,1,1,1,0,0,1};
    bit ok;
    start_frame(8'h3C, 1'b0, 1'b0, ok);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL b2b_handshake: Busy never rose, expected within 20 cycles");
    DATA_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge CLK);
      n_total++;
      if (TX_OUT === 1'(exp_bits[i]) && Busy === 1'b1) n_pass++;
      else $display("FAIL b2b_f1_bit%0d: TX_OUT=%b Busy=%b, expected %0d and 1", i, TX_OUT, Busy, exp_bits[i]);
    end
    @(negedge CLK);
    n_total++;
    if (TX_OUT === 1'b1 && Busy === 1'b0) n_pass++;
    else $display("FAIL b2b_gap: TX_OUT=%b Busy=%b, expected 1 and 0", TX_OUT, Busy);
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      n_total++;
      if (TX_OUT === 1'(exp_bits[i]) && Busy === 1'b1) n_pass++;
      else $display("FAIL b2b_f2_bit%0d: TX_OUT=%b Busy=%b, expected %0d and 1", i, TX_OUT, Busy, exp_bits[i]);
    end
    // Data bit 5 is on the line: abort the frame.
    RST = 1'b0;
    @(negedge CLK);
    n_total++;
    if (TX_OUT === 1'b1 && Busy === 1'b0) n_pass++;
    else $display("FAIL b2b_abort: TX_OUT=%b Busy=%b, expected 1 and 0", TX_OUT, Busy);
    DATA_VALID = 1'b0;
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_total++;
      if (TX_OUT === 1'b1 && Busy === 1'b0) n_pass++;
      else $display("FAIL b2b_post_abort%0d: TX_OUT=%b Busy=%b, expected 1 and 0", i, TX_OUT, Busy);
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    RST = 1'b0; DATA_VALID = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    test_reset();
    test_no_parity();
    test_parity();
    test_busy_ignore();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
